// File: rtl/sseg_pkg.sv
// sseg_pkg: shared digit type, seven-segment decode table and powers of ten.
package sseg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic   ok;
    digit_t digit;
  } sseg_dec_t;

  localparam logic [31:0] POW10 [0:7] = '{
    32'd1, 32'd10, 32'd100, 32'd1000,
    32'd10000, 32'd100000, 32'd1000000, 32'd10000000
  };

  // Active-low abcdefg pattern to hex digit; unknown patterns give ok=0, digit=F.
  function automatic sseg_dec_t sseg_decode(input logic [SEG_W-1:0] seg);
    sseg_dec_t r;
    r.ok    = 1'b1;
    r.digit = 4'h0;
    case (seg)
      7'b0000001: r.digit = 4'h0;
      7'b1001111: r.digit = 4'h1;
      7'b0010010: r.digit = 4'h2;
      7'b0000110: r.digit = 4'h3;
      7'b1001100: r.digit = 4'h4;
      7'b0100100: r.digit = 4'h5;
      7'b0100000: r.digit = 4'h6;
      7'b0001111,
      7'b0001101,
      7'b0001110: r.digit = 4'h7;
      7'b0000000: r.digit = 4'h8;
      7'b0000100,
      7'b0001100: r.digit = 4'h9;
      7'b0001000,
      7'b0000010: r.digit = 4'hA;
      7'b1100000: r.digit = 4'hB;
      7'b0110001,
      7'b1110010: r.digit = 4'hC;
      7'b1000010: r.digit = 4'hD;
      7'b0110000,
      7'b0010000: r.digit = 4'hE;
      7'b0111000: r.digit = 4'hF;
      default: begin
        r.ok    = 1'b0;
        r.digit = 4'hF;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sseg_frame_filter.sv
// sseg_frame_filter: multi-frame stability filter and output register.
// Optional decimal-point tracking under SSEG_DP_CAPTURE_EN.
module sseg_frame_filter
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_done,
  input  logic [4*N_DIGITS-1:0]   frame_buf,
`ifdef SSEG_DP_CAPTURE_EN
  input  logic [N_DIGITS-1:0]     dp_buf,
  output logic [N_DIGITS-1:0]     dp_mask,
`endif
  output logic [4*N_DIGITS-1:0]   value_hex,
  output logic [4*N_DIGITS-1:0]   value_dec,
  output logic                    valid,
  output logic                    dec_err
);

  localparam int unsigned HEX_W = 4 * N_DIGITS;
`ifdef SSEG_DP_CAPTURE_EN
  localparam int unsigned FRAME_W = 5 * N_DIGITS;
`else
  localparam int unsigned FRAME_W = 4 * N_DIGITS;
`endif
  localparam int unsigned CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

  logic [FRAME_W-1:0] frame_c;
  logic [FRAME_W-1:0] shown_c;
  logic [FRAME_W-1:0] cand_q;
  logic [FRAME_W-1:0] cand_nxt_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt_c;
  logic               update_c;
  logic [31:0]        dec_sum_c;
  logic               dec_err_c;
  digit_t             dig_c;

  // Frame and displayed value, with decimal points as the top bits when tracked.
`ifdef SSEG_DP_CAPTURE_EN
  assign frame_c = {dp_buf, frame_buf};
  assign shown_c = {dp_mask, value_hex};
`else
  assign frame_c = frame_buf;
  assign shown_c = value_hex;
`endif

  // Candidate tracking and stability counting on each completed frame.
  always_comb begin
    cand_nxt_c = cand_q;
    cnt_nxt_c  = cnt_q;
    if (frame_done) begin
      if (frame_c == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_nxt_c = cnt_q + 1'b1;
      end else begin
        cand_nxt_c = frame_c;
        cnt_nxt_c  = CNT_W'(1);
      end
    end
    update_c = frame_done && (cnt_nxt_c == CNT_MAX) && (cand_nxt_c != shown_c);
  end

  // Decimal conversion of the candidate digits; zero when any digit exceeds 9.
  always_comb begin
    dec_sum_c = '0;
    dec_err_c = 1'b0;
    dig_c     = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      dig_c = cand_nxt_c[4*i +: 4];
      if (dig_c > 4'd9) dec_err_c = 1'b1;
      dec_sum_c = dec_sum_c + 32'(dig_c) * POW10[i];
    end
    if (dec_err_c) dec_sum_c = '0;
  end

  // Candidate, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= '1;
      cnt_q     <= '0;
      value_hex <= '0;
      value_dec <= '0;
      dec_err   <= 1'b0;
      valid     <= 1'b0;
`ifdef SSEG_DP_CAPTURE_EN
      dp_mask   <= '0;
`endif
    end else begin
      cand_q <= cand_nxt_c;
      cnt_q  <= cnt_nxt_c;
      valid  <= update_c;
      if (update_c) begin
        value_hex <= cand_nxt_c[HEX_W-1:0];
        value_dec <= HEX_W'(dec_sum_c);
        dec_err   <= dec_err_c;
`ifdef SSEG_DP_CAPTURE_EN
        dp_mask   <= cand_nxt_c[FRAME_W-1:HEX_W];
`endif
      end
    end
  end

endmodule

// File: rtl/sseg_scan_monitor.sv
// sseg_scan_monitor: reconstructs the value on a multiplexed active-low
// seven-segment display. Define SSEG_DP_CAPTURE_EN to add dp / dp_mask.
module sseg_scan_monitor
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS         = 8,
  parameter int unsigned C_SWAP_SEGMENTS  = 0,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned STABLE_FRAMES    = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        segments,
  input  logic [N_DIGITS-1:0]     anodes,
`ifdef SSEG_DP_CAPTURE_EN
  input  logic                    dp,
  output logic [N_DIGITS-1:0]     dp_mask,
`endif
  output logic [4*N_DIGITS-1:0]   value_hex,
  output logic [4*N_DIGITS-1:0]   value_dec,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    pat_err,
  output logic                    ghost_err,
  output logic                    dec_err,
  output logic                    blank
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [N_DIGITS-1:0]   sel_c;
  logic [SEG_W-1:0]      seg_c;
  sseg_dec_t             dec_c;
  logic                  none_c;
  logic                  one_c;
  logic                  multi_c;
  logic [N_DIGITS-1:0]   seen_q;
  logic [N_DIGITS-1:0]   seen_nxt_c;
  logic                  frame_full_c;
  logic [4*N_DIGITS-1:0] frame_buf_q;
  logic [TO_W-1:0]       to_cnt_q;
`ifdef SSEG_DP_CAPTURE_EN
  logic [N_DIGITS-1:0]   dp_buf_q;
`endif

  // Normalise anode polarity, optionally bit-reverse segments, then decode.
  always_comb begin
    sel_c = (ANODE_ACTIVE_LOW != 0) ? ~anodes : anodes;
    for (int b = 0; b < int'(SEG_W); b++) begin
      seg_c[b] = (C_SWAP_SEGMENTS != 0) ? segments[int'(SEG_W) - 1 - b] : segments[b];
    end
    dec_c        = sseg_decode(seg_c);
    none_c       = (sel_c == '0);
    one_c        = $onehot(sel_c);
    multi_c      = !none_c && !one_c;
    seen_nxt_c   = one_c ? (seen_q | sel_c) : seen_q;
    frame_full_c = (seen_nxt_c == '1);
  end

  // Digit capture, seen mask, frame completion and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf_q <= '0;
      seen_q      <= '0;
      frame_done  <= 1'b0;
      pat_err     <= 1'b0;
      ghost_err   <= 1'b0;
`ifdef SSEG_DP_CAPTURE_EN
      dp_buf_q    <= '0;
`endif
    end else begin
      frame_done <= frame_full_c;
      seen_q     <= frame_full_c ? '0 : seen_nxt_c;
      if (multi_c) ghost_err <= 1'b1;
      if (one_c) begin
        if (!dec_c.ok) pat_err <= 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
          if (sel_c[i]) begin
            frame_buf_q[4*i +: 4] <= dec_c.digit;
`ifdef SSEG_DP_CAPTURE_EN
            dp_buf_q[i] <= ~dp;
`endif
          end
        end
      end
    end
  end

  // Idle-anode timeout: saturating count, blank once TIMEOUT_CYCLES idle cycles seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      blank    <= 1'b0;
    end else if (!none_c) begin
      to_cnt_q <= '0;
      blank    <= 1'b0;
    end else begin
      if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
      if (to_cnt_q >= TO_LAST) blank <= 1'b1;
    end
  end

  sseg_frame_filter #(
    .N_DIGITS      (N_DIGITS),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .frame_buf  (frame_buf_q),
`ifdef SSEG_DP_CAPTURE_EN
    .dp_buf     (dp_buf_q),
    .dp_mask    (dp_mask),
`endif
    .value_hex  (value_hex),
    .value_dec  (value_dec),
    .valid      (valid),
    .dec_err    (dec_err)
  );

endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Directed bench for sseg_scan_monitor: three instances (8-digit active-low,
// 4-digit, 8-digit swapped/active-high with single-frame stability).
module tb_sseg_scan_monitor;

  logic clk;
  logic rst_n;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [7:0] an_a, an_c;
  logic [3:0] an_b;
  logic       dp_c;
  int         dp_digit_c;

  logic [31:0] hex_a, dec_a, hex_c, dec_c;
  logic [15:0] hex_b, dec_b;
  logic valid_a, fd_a, pat_a, ghost_a, derr_a, blank_a;
  logic valid_b, fd_b, pat_b, ghost_b, derr_b, blank_b;
  logic valid_c, fd_c, pat_c, ghost_c, derr_c, blank_c;
`ifdef SSEG_DP_CAPTURE_EN
  logic dp_a, dp_b;
  logic [7:0] dpm_a, dpm_c;
  logic [3:0] dpm_b;
  assign dp_a = 1'b1;
  assign dp_b = 1'b1;
`endif

  int tests = 0;
  int fails = 0;
  int nv_a = 0, nfd_a = 0, nv_b = 0, nv_c = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_a) nv_a++;
    if (fd_a)    nfd_a++;
    if (valid_b) nv_b++;
    if (valid_c) nv_c++;
  end

  sseg_scan_monitor #(.N_DIGITS(8), .C_SWAP_SEGMENTS(0), .ANODE_ACTIVE_LOW(1),
                      .STABLE_FRAMES(2), .TIMEOUT_CYCLES(100)) u_a (
    .clk(clk), .rst_n(rst_n), .segments(seg_a), .anodes(an_a),
`ifdef SSEG_DP_CAPTURE_EN
    .dp(dp_a), .dp_mask(dpm_a),
`endif
    .value_hex(hex_a), .value_dec(dec_a), .valid(valid_a), .frame_done(fd_a),
    .pat_err(pat_a), .ghost_err(ghost_a), .dec_err(derr_a), .blank(blank_a));

  sseg_scan_monitor #(.N_DIGITS(4), .C_SWAP_SEGMENTS(0), .ANODE_ACTIVE_LOW(1),
                      .STABLE_FRAMES(2), .TIMEOUT_CYCLES(100)) u_b (
    .clk(clk), .rst_n(rst_n), .segments(seg_b), .anodes(an_b),
`ifdef SSEG_DP_CAPTURE_EN
    .dp(dp_b), .dp_mask(dpm_b),
`endif
    .value_hex(hex_b), .value_dec(dec_b), .valid(valid_b), .frame_done(fd_b),
    .pat_err(pat_b), .ghost_err(ghost_b), .dec_err(derr_b), .blank(blank_b));

  sseg_scan_monitor #(.N_DIGITS(8), .C_SWAP_SEGMENTS(1), .ANODE_ACTIVE_LOW(0),
                      .STABLE_FRAMES(1), .TIMEOUT_CYCLES(100)) u_c (
    .clk(clk), .rst_n(rst_n), .segments(seg_c), .anodes(an_c),
`ifdef SSEG_DP_CAPTURE_EN
    .dp(dp_c), .dp_mask(dpm_c),
`endif
    .value_hex(hex_c), .value_dec(dec_c), .valid(valid_c), .frame_done(fd_c),
    .pat_err(pat_c), .ghost_err(ghost_c), .dec_err(derr_c), .blank(blank_c));

  // Standard active-low abcdefg patterns.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Alternate glyphs where they exist.
  function automatic logic [6:0] enc_alt(input logic [3:0] d);
    case (d)
      4'h7: return 7'b0001101;
      4'h9: return 7'b0001100;
      4'hA: return 7'b0000010;
      4'hC: return 7'b1110010;
      4'hE: return 7'b0010000;
      default: return enc(d);
    endcase
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] s);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = s[6-b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Select digit idx (idx < 0 = none) on instance w with pattern seg.
  task automatic set_sel(input int w, input int idx, input logic [6:0] seg);
    logic [7:0] oh;
    oh = '0;
    if (idx >= 0) oh[idx] = 1'b1;
    case (w)
      0: begin an_a = ~oh; seg_a = seg; end
      1: begin an_b = ~oh[3:0]; seg_b = seg; end
      default: begin
        an_c  = oh;
        seg_c = rev7(seg);
        dp_c  = !(idx >= 0 && idx == dp_digit_c);
      end
    endcase
  endtask

  // Scan digits first..last, one digit per 4 clk (1 selected + 3 dark).
  task automatic scan(input int w, input int first, input int last, input logic [31:0] hex,
                      input logic [7:0] bad, input logic [7:0] alt, input bit lww);
    for (int i = first; i <= last; i++) begin
      logic [3:0] d;
      logic [6:0] s;
      d = hex[4*i +: 4];
      s = bad[i] ? 7'h7F : (alt[i] ? enc_alt(d) : enc(d));
      if (lww && i == first) begin
        set_sel(w, i, enc(~d));
        tick();
      end
      set_sel(w, i, s);
      tick();
      set_sel(w, -1, 7'h7F);
      repeat ((lww && i == first) ? 2 : 3) tick();
    end
  endtask

  typedef struct {
    logic [31:0] hex;
    int          nv;
    logic [31:0] hex_exp;
    logic [31:0] dec_exp;
  } vec_t;

  vec_t tbl [7];
  int   v0, f0;

  initial begin
    tbl[0] = '{32'h12345678, 0, 32'h00000000, 32'd0};
    tbl[1] = '{32'h12345678, 1, 32'h12345678, 32'd12345678};
    tbl[2] = '{32'h12345679, 0, 32'h12345678, 32'd12345678};
    tbl[3] = '{32'h12345678, 0, 32'h12345678, 32'd12345678};
    tbl[4] = '{32'h12345678, 0, 32'h12345678, 32'd12345678};
    tbl[5] = '{32'h12345679, 0, 32'h12345678, 32'd12345678};
    tbl[6] = '{32'h12345679, 1, 32'h12345679, 32'd12345679};

    dp_digit_c = -1;
    rst_n = 1'b0;
    set_sel(0, -1, 7'h7F);
    set_sel(1, -1, 7'h7F);
    set_sel(2, -1, 7'h7F);
    repeat (3) tick();
    check("reset_hex", hex_a, 32'h0);
    check("reset_dec", dec_a, 32'h0);
    check("reset_flags", {26'b0, valid_a, fd_a, pat_a, ghost_a, derr_a, blank_a}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Main scanning with one-frame glitch rejection.
    for (int k = 0; k < 7; k++) begin
      v0 = nv_a;
      scan(0, 0, 7, tbl[k].hex, 8'h00, 8'h00, 1'b0);
      check($sformatf("tbl%0d_valid_cnt", k), 32'(nv_a - v0), 32'(tbl[k].nv));
      check($sformatf("tbl%0d_hex", k), hex_a, tbl[k].hex_exp);
      check($sformatf("tbl%0d_dec", k), dec_a, tbl[k].dec_exp);
    end

    // Latency: frame_done one cycle, valid two cycles after last capture.
    scan(0, 0, 7, 32'h87654321, 8'h00, 8'h00, 1'b0);
    scan(0, 0, 6, 32'h87654321, 8'h00, 8'h00, 1'b0);
    set_sel(0, 7, enc(4'h8));
    tick();
    check("lat_frame_done", 32'(fd_a), 32'h1);
    check("lat_valid_early", 32'(valid_a), 32'h0);
    set_sel(0, -1, 7'h7F);
    tick();
    check("lat_valid", 32'(valid_a), 32'h1);
    check("lat_hex", hex_a, 32'h87654321);
    tick();
    check("lat_valid_one_pulse", 32'(valid_a), 32'h0);

    // Ghosting: two anodes in one cycle must not mark any digit seen.
    an_a  = 8'b1111_1100;
    seg_a = enc(4'h8);
    tick();
    set_sel(0, -1, 7'h7F);
    tick();
    check("ghost_err", 32'(ghost_a), 32'h1);
    check("ghost_no_pat", 32'(pat_a), 32'h0);
    f0 = nfd_a;
    scan(0, 1, 7, 32'h87654321, 8'h00, 8'h00, 1'b0);
    check("ghost_no_seen", 32'(nfd_a - f0), 32'h0);
    scan(0, 0, 0, 32'h87654321, 8'h00, 8'h00, 1'b0);
    check("ghost_frame_done", 32'(nfd_a - f0), 32'h1);

    // Undecodable pattern on digit 3 reads back as F.
    v0 = nv_a;
    scan(0, 0, 7, 32'h87654321, 8'h08, 8'h00, 1'b0);
    scan(0, 0, 7, 32'h87654321, 8'h08, 8'h00, 1'b0);
    check("pat_err", 32'(pat_a), 32'h1);
    check("pat_valid_cnt", 32'(nv_a - v0), 32'h1);
    check("pat_hex", hex_a, 32'h8765F321);
    check("pat_dec_err", 32'(derr_a), 32'h1);
    check("pat_dec_zero", dec_a, 32'h0);

    // Last write wins inside an anode window.
    scan(0, 0, 7, 32'h12345678, 8'h00, 8'h00, 1'b1);
    scan(0, 0, 7, 32'h12345678, 8'h00, 8'h00, 1'b1);
    check("lww_hex", hex_a, 32'h12345678);
    check("lww_dec", dec_a, 32'd12345678);
    check("lww_dec_err", 32'(derr_a), 32'h0);

    // Blank timeout at 100 idle cycles, clear one cycle after scanning resumes.
    set_sel(0, 0, enc(4'h8));
    tick();
    set_sel(0, -1, 7'h7F);
    repeat (99) tick();
    check("blank_99", 32'(blank_a), 32'h0);
    tick();
    check("blank_100", 32'(blank_a), 32'h1);
    set_sel(0, 0, enc(4'h8));
    tick();
    check("blank_clear", 32'(blank_a), 32'h0);
    set_sel(0, -1, 7'h7F);
    tick();

    // Four-digit display with a hex digit and alternate glyphs.
    v0 = nv_b;
    scan(1, 0, 3, 32'h000000A0, 8'h00, 8'h00, 1'b0);
    scan(1, 0, 3, 32'h000000A0, 8'h00, 8'hFF, 1'b0);
    check("b_valid_cnt", 32'(nv_b - v0), 32'h1);
    check("b_hex", 32'(hex_b), 32'h00A0);
    check("b_dec_err", 32'(derr_b), 32'h1);
    check("b_dec_zero", 32'(dec_b), 32'h0);
    scan(1, 0, 3, 32'h00000909, 8'h00, 8'h01, 1'b0);
    scan(1, 0, 3, 32'h00000909, 8'h00, 8'h00, 1'b0);
    check("b_hex_909", 32'(hex_b), 32'h0909);
    check("b_dec_909", 32'(dec_b), 32'd909);
    check("b_dec_err_clr", 32'(derr_b), 32'h0);
    check("b_pat_err", 32'(pat_b), 32'h0);

    // Swapped segments, active-high anodes, single-frame stability.
    dp_digit_c = 2;
    v0 = nv_c;
    scan(2, 0, 7, 32'h12345678, 8'h00, 8'h00, 1'b0);
    check("c_valid_cnt", 32'(nv_c - v0), 32'h1);
    check("c_hex", hex_c, 32'h12345678);
    check("c_dec", dec_c, 32'd12345678);
`ifdef SSEG_DP_CAPTURE_EN
    check("c_dp_mask", 32'(dpm_c), 32'h04);
`endif
    scan(2, 0, 7, 32'hE7C07E9C, 8'h00, 8'hFF, 1'b0);
    check("c_alt_hex", hex_c, 32'hE7C07E9C);
    check("c_alt_dec_err", 32'(derr_c), 32'h1);
    check("c_pat_err", 32'(pat_c), 32'h0);

    // Reset mid-frame discards the partial frame and sticky flags.
    scan(0, 0, 3, 32'h99999999, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hex", hex_a, 32'h0);
    check("mid_rst_dec", dec_a, 32'h0);
    check("mid_rst_flags", {26'b0, valid_a, fd_a, pat_a, ghost_a, derr_a, blank_a}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    v0 = nv_a;
    scan(0, 0, 7, 32'h11111111, 8'h00, 8'h00, 1'b0);
    check("post_rst_frame1_valid", 32'(nv_a - v0), 32'h0);
    scan(0, 0, 7, 32'h11111111, 8'h00, 8'h00, 1'b0);
    check("post_rst_frame2_valid", 32'(nv_a - v0), 32'h1);
    check("post_rst_hex", hex_a, 32'h11111111);
    check("post_rst_dec", dec_a, 32'd11111111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
